// File: rtl/cronometro_ctrl.sv
// Stopwatch control FSM: turns debounced start/stop and lap buttons into counter
// enable/clear, a display-freeze flag, a saturating lap count and a long-press clear.
module cronometro_ctrl #(
  parameter int unsigned LONG_PRESS = 150,
  parameter int unsigned LAP_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             btn_ss,
  input  logic             btn_lap,
  input  logic             overflow,
  output logic             count_en,
  output logic             count_clr,
  output logic             disp_freeze,
  output logic [LAP_W-1:0] lap_cnt,
  output logic [1:0]       state
);

  localparam int unsigned HOLD_W = $clog2(LONG_PRESS + 1);
  localparam logic [LAP_W-1:0]  LAP_MAX  = '1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS);
  localparam logic [HOLD_W-1:0] HOLD_ARM = HOLD_W'(LONG_PRESS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LAP   = 2'b10,
    PAUSE = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [LAP_W-1:0]  lap_q, lap_d;
  logic              clr_q, clr_d;
  logic [HOLD_W-1:0] hold_q;
  logic              ss_prev, lap_prev;
  logic              ss_rise, lap_rise, long_clr;

  assign ss_rise  = btn_ss & ~ss_prev;
  assign lap_rise = btn_lap & ~lap_prev;
  // Fires once per press: hold saturates past the arming value until release.
  assign long_clr = tick & btn_ss & (hold_q == HOLD_ARM);

  // Button history and long-press hold counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      ss_prev  <= 1'b1;
      lap_prev <= 1'b1;
      hold_q   <= '0;
    end else begin
      ss_prev  <= btn_ss;
      lap_prev <= btn_lap;
      if (!btn_ss)
        hold_q <= '0;
      else if (tick && (hold_q != HOLD_MAX))
        hold_q <= hold_q + HOLD_W'(1);
    end
  end

  // State, lap count and clear pulse registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      lap_q   <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lap_q   <= lap_d;
      clr_q   <= clr_d;
    end
  end

  // Next-state logic; events in priority order long_clr, overflow, ss_rise, lap_rise
  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    clr_d   = 1'b0;
    if (long_clr) begin
      state_d = IDLE;
      lap_d   = '0;
      clr_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_rise) state_d = RUN;
        end
        RUN: begin
          if (overflow || ss_rise) begin
            state_d = PAUSE;
          end else if (lap_rise) begin
            state_d = LAP;
            if (lap_q != LAP_MAX) lap_d = lap_q + LAP_W'(1);
          end
        end
        LAP: begin
          if (overflow || ss_rise) state_d = PAUSE;
          else if (lap_rise)       state_d = RUN;
        end
        PAUSE: begin
          // A start press cannot resume while the counter sits at its maximum.
          if (ss_rise) begin
            if (!overflow) state_d = RUN;
          end else if (lap_rise) begin
            state_d = IDLE;
            lap_d   = '0;
            clr_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign count_en    = (state_q == RUN) || (state_q == LAP);
  assign disp_freeze = (state_q == LAP);
  assign count_clr   = clr_q;
  assign lap_cnt     = lap_q;
  assign state       = state_q;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Self-checking bench for cronometro_ctrl: table-driven cycle vectors plus
// hand-written long-press and lap-saturation sequences through a scoreboard queue.
module tb_cronometro_ctrl;

  localparam int unsigned LP    = 4;
  localparam int unsigned LAP_W = 2;
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_LAP   = 2'b10;
  localparam logic [1:0] S_PAUSE = 2'b11;

  typedef struct packed {
    logic rst;
    logic tick;
    logic ss;
    logic lap;
    logic ov;
  } in_t;

  typedef struct packed {
    logic [1:0]       st;
    logic             en;
    logic             clr;
    logic             frz;
    logic [LAP_W-1:0] lap;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst, tick, btn_ss, btn_lap, overflow;
  logic             count_en, count_clr, disp_freeze;
  logic [LAP_W-1:0] lap_cnt;
  logic [1:0]       state;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;
  exp_t        sb[$];
  vec_t        tbl[$];

  cronometro_ctrl #(.LONG_PRESS(LP), .LAP_W(LAP_W)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_ss(btn_ss), .btn_lap(btn_lap),
    .overflow(overflow), .count_en(count_en), .count_clr(count_clr),
    .disp_freeze(disp_freeze), .lap_cnt(lap_cnt), .state(state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic t, input logic s,
                              input logic l, input logic o, input logic [1:0] st,
                              input logic en, input logic clr, input logic frz,
                              input logic [LAP_W-1:0] lp);
    vec_t v;
    v.i = '{rst: r, tick: t, ss: s, lap: l, ov: o};
    v.e = '{st: st, en: en, clr: clr, frz: frz, lap: lp};
    return v;
  endfunction

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(input string name, input vec_t v);
    exp_t exp, act;
    @(negedge clk);
    rst = v.i.rst; tick = v.i.tick; btn_ss = v.i.ss; btn_lap = v.i.lap; overflow = v.i.ov;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    act = '{st: state, en: count_en, clr: count_clr, frz: disp_freeze, lap: lap_cnt};
    n_vec++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %b", name, act);
    end else begin
      exp = sb.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s @%0t: got st=%b en=%b clr=%b frz=%b lap=%0d, want st=%b en=%b clr=%b frz=%b lap=%0d",
                 name, $time, act.st, act.en, act.clr, act.frz, act.lap,
                 exp.st, exp.en, exp.clr, exp.frz, exp.lap);
      end
    end
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; btn_ss = 1'b0; btn_lap = 1'b0; overflow = 1'b0;

    //          rst t ss lp ov  state   en clr frz lap
    // Reset with start held: no edge until a real 0->1
    tbl.push_back(mk(0, 0, 1, 0, 0, S_IDLE,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, S_IDLE,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, S_IDLE,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, S_IDLE,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, S_IDLE,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, S_RUN,   1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, S_RUN,   1, 0, 0, 0));
    // Three lap presses: LAP, RUN, LAP
    tbl.push_back(mk(1, 0, 0, 1, 0, S_LAP,   1, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, S_LAP,   1, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, S_RUN,   1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, S_RUN,   1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, S_LAP,   1, 0, 1, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, S_LAP,   1, 0, 1, 2));
    tbl.push_back(mk(1, 0, 0, 1, 0, S_RUN,   1, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, S_RUN,   1, 0, 0, 2));
    // Simultaneous start and lap in RUN: only start acts
    tbl.push_back(mk(1, 0, 1, 1, 0, S_PAUSE, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, S_PAUSE, 0, 0, 0, 2));
    // Lap in PAUSE clears, pulse lasts one cycle
    tbl.push_back(mk(1, 0, 0, 1, 0, S_IDLE,  0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, S_IDLE,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, S_IDLE,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, S_IDLE,  0, 0, 0, 0));
    // Overflow in RUN pauses; start blocked while overflow held
    tbl.push_back(mk(1, 0, 1, 0, 0, S_RUN,   1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, S_PAUSE, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, S_PAUSE, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, S_PAUSE, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, S_RUN,   1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, S_RUN,   1, 0, 0, 0));
    // Overflow in LAP, then lap clear from PAUSE with overflow still high
    tbl.push_back(mk(1, 0, 0, 1, 0, S_LAP,   1, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, S_PAUSE, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, S_PAUSE, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 1, S_IDLE,  0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, S_IDLE,  0, 0, 0, 0));
    // Reset mid-lap: back to IDLE with no clear pulse
    tbl.push_back(mk(1, 0, 1, 0, 0, S_RUN,   1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, S_RUN,   1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, S_LAP,   1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, S_IDLE,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, S_IDLE,  0, 0, 0, 0));
    // Reach PAUSE with a non-zero lap count
    tbl.push_back(mk(1, 0, 1, 0, 0, S_RUN,   1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, S_RUN,   1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, S_LAP,   1, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, S_LAP,   1, 0, 1, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, S_PAUSE, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, S_PAUSE, 0, 0, 0, 1));

    for (int k = 0; k < tbl.size(); k++)
      step($sformatf("vec%0d", k), tbl[k]);

    // Long press from PAUSE: press resumes, 4th tick clears once, ticks 5-6 inert
    step("lp_press", mk(1, 0, 1, 0, 0, S_RUN, 1, 0, 0, 1));
    for (int t = 1; t <= 6; t++) begin
      if (t < int'(LP)) begin
        step($sformatf("lp_tick%0d", t), mk(1, 1, 1, 0, 0, S_RUN, 1, 0, 0, 1));
        step($sformatf("lp_gap%0d", t),  mk(1, 0, 1, 0, 0, S_RUN, 1, 0, 0, 1));
      end else if (t == int'(LP)) begin
        step($sformatf("lp_tick%0d", t), mk(1, 1, 1, 0, 0, S_IDLE, 0, 1, 0, 0));
        step($sformatf("lp_gap%0d", t),  mk(1, 0, 1, 0, 0, S_IDLE, 0, 0, 0, 0));
      end else begin
        step($sformatf("lp_tick%0d", t), mk(1, 1, 1, 0, 0, S_IDLE, 0, 0, 0, 0));
        step($sformatf("lp_gap%0d", t),  mk(1, 0, 1, 0, 0, S_IDLE, 0, 0, 0, 0));
      end
    end
    step("lp_release", mk(1, 0, 0, 0, 0, S_IDLE, 0, 0, 0, 0));
    step("lp_repress", mk(1, 0, 1, 0, 0, S_RUN,  1, 0, 0, 0));
    step("lp_repress2", mk(1, 0, 0, 0, 0, S_RUN, 1, 0, 0, 0));

    // Lap counter saturates at its maximum and never wraps
    for (int n = 0; n < 5; n++) begin
      logic [LAP_W-1:0] want;
      want = (n + 1 > 3) ? LAP_W'(3) : LAP_W'(n + 1);
      step($sformatf("sat_lap%0d", n),  mk(1, 0, 0, 1, 0, S_LAP, 1, 0, 1, want));
      step($sformatf("sat_lrel%0d", n), mk(1, 0, 0, 0, 0, S_LAP, 1, 0, 1, want));
      step($sformatf("sat_run%0d", n),  mk(1, 0, 0, 1, 0, S_RUN, 1, 0, 0, want));
      step($sformatf("sat_rrel%0d", n), mk(1, 0, 0, 0, 0, S_RUN, 1, 0, 0, want));
    end

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/cronometro_ctrl.md
# cronometro_ctrl

Control FSM for the stopwatch datapath. It turns debounced start/stop and lap push-buttons into the counter's `enable` and clear controls, plus a display-freeze flag for lap times. It sits between the debouncers/clock divider and the BCD counter chain. It also counts laps and supports a long-press clear.

## Interface

Parameters:
- `LONG_PRESS`, default 150: number of `tick` pulses `btn_ss` must stay high to force a clear.
- `LAP_W`, default 4: width of the lap counter.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-low reset.
- `tick`  in  1  one-`clk`-wide pulse from the clock divider; time base for long-press.
- `btn_ss`  in  1  debounced start/stop button, active-high level.
- `btn_lap`  in  1  debounced lap/reset button, active-high level.
- `overflow`  in  1  level from the counter: count is at maximum.
- `count_en`  out  1  enable to the counter chain.
- `count_clr`  out  1  one-cycle clear pulse to the counter chain.
- `disp_freeze`  out  1  display holds its latched value while high.
- `lap_cnt`  out  `LAP_W`  number of laps taken since the last clear.
- `state`  out  2  current FSM state, for debug and LEDs.

## Operation

- Edge detect:
  - `ss_prev` and `lap_prev` register the buttons each `clk`.
  - Both reset to 1, so a button held through reset gives no edge.
  - `ss_rise = btn_ss & ~ss_prev`; `lap_rise` is formed the same way.
- Hold counter `hold`:
  - Clears to 0 whenever `btn_ss` = 0.
  - Increments on `tick` while `btn_ss` = 1, and saturates at `LONG_PRESS`.
  - `long_clr` is asserted for exactly one cycle: the cycle where `tick`=1, `btn_ss`=1 and `hold` = `LONG_PRESS`-1.
- States: IDLE=2'b00, RUN=2'b01, LAP=2'b10, PAUSE=2'b11.
- Event priority, highest first: `long_clr`, then `overflow`, then `ss_rise`, then `lap_rise`.
- Transitions:
  - Any state, on `long_clr`: go to IDLE, pulse `count_clr`, set `lap_cnt` to 0.
  - IDLE, on `ss_rise`: go to RUN. `lap_rise` is ignored.
  - RUN:
    - `overflow` goes to PAUSE.
    - `ss_rise` goes to PAUSE.
    - `lap_rise` goes to LAP and increments `lap_cnt`.
  - LAP:
    - `overflow` goes to PAUSE.
    - `ss_rise` goes to PAUSE.
    - `lap_rise` goes to RUN with no increment.
  - PAUSE:
    - `ss_rise` goes to RUN, unless `overflow`=1, in which case it stays in PAUSE.
    - `lap_rise` goes to IDLE, pulses `count_clr` and sets `lap_cnt` to 0.
  - `overflow` is ignored in IDLE and PAUSE.
- Outputs:
  - `count_en` = 1 in RUN and LAP.
  - `disp_freeze` = 1 in LAP only.
  - `state` = state register.
- Arithmetic:
  - `lap_cnt` saturates at 2^`LAP_W`-1 and never wraps.
  - `hold` width is clog2(`LONG_PRESS`+1).
- When `ss_rise` and `lap_rise` occur in the same cycle, only `ss_rise` acts.

## Timing

- Reset (`rst`=0 at a `clk` edge) sets:
  - state = IDLE
  - `count_en` = 0, `count_clr` = 0, `disp_freeze` = 0
  - `lap_cnt` = 0
  - `hold` = 0
  - `ss_prev` = `lap_prev` = 1
- Reset applied mid-RUN takes effect at that edge; `count_clr` is not pulsed.
- State, `lap_cnt` and `count_clr` are registered.
- `count_en` and `disp_freeze` decode the state register combinationally.
- Button latency:
  - Let cycle N be the first cycle where `btn_ss`=1 after being low.
  - `ss_rise` is high in cycle N.
  - The new state, and therefore `count_en`, is visible from cycle N+1.
- `count_clr` is high for exactly one cycle: the cycle in which the state first reads IDLE after a clear.
- Long-press timing:
  - The clear fires `LONG_PRESS` ticks after the press.
  - The initial `ss_rise` has already acted by then, so an IDLE→RUN→clear sequence is legal.
  - The clear fires once per press and is not re-armed until `btn_ss` returns to 0.
- An `overflow` while running reaches PAUSE one cycle later, so `count_en` drops one cycle after `overflow` rises.

## Test plan

- Reset with `btn_ss`=1 held, then release reset → state stays IDLE and `count_en`=0 until `btn_ss` toggles 0→1. After that press, state=RUN and `count_en`=1 one cycle later.
- RUN, pulse `btn_lap` three times → states LAP, RUN, LAP; `lap_cnt`=2; `disp_freeze` is high only in LAP; `count_en` stays 1 throughout.
- RUN, `ss_rise` and `lap_rise` in the same cycle → next state PAUSE; `lap_cnt` unchanged.
- PAUSE, `lap_rise` → state IDLE; `count_clr` high for exactly one cycle; `lap_cnt`=0.
- `LONG_PRESS`=4: from PAUSE, hold `btn_ss` for 6 ticks → RUN after the first cycle. On the 4th tick: IDLE and a single `count_clr`. Ticks 5 and 6 cause no further action.
- RUN with `overflow`=1 → PAUSE the next cycle. A following `ss_rise` while `overflow` is still 1 leaves the state in PAUSE.
